// File: rtl/tanimoto_pkg.sv
// Shared types and LFSR constants for the tanimoto stimulus generator.
// Galois LFSR step helper used by the word generator.
package tanimoto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_THRESH,
        ST_STREAM,
        ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS         = 32'h80200003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h1;

    // Right-shifting Galois form: the bit shifted out selects the tap XOR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ({1'b0, s[31:1]} ^ LFSR_TAPS) : {1'b0, s[31:1]};
    endfunction

endpackage

// File: rtl/lfsr_word_gen.sv
// Unrolled LFSR: emits NUM_WORDS consecutive states (word 0 = current state in
// the low 32 bits) plus the state NUM_WORDS steps ahead.
module lfsr_word_gen
    import tanimoto_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic [31:0]             state_in,
    output logic [31:0]             state_out,
    output logic [NUM_WORDS*32-1:0] data
);

    logic [31:0] s;

    always_comb begin
        s    = state_in;
        data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            data[i*32 +: 32] = s;
            s                = lfsr_step(s);
        end
        state_out = s;
    end

endmodule

// File: rtl/tanimoto_stim_gen.sv
// Pseudo-random beat source for tanimoto_top with optional threshold ramp load.
// Define TANIMOTO_STIM_THRESH_LOAD_EN to include the THRESH (BRAM load) phase.
module tanimoto_stim_gen
    import tanimoto_pkg::*;
#(
    parameter int BUS_WIDTH      = 128,
    parameter int VECTOR_WIDTH   = 920,
    parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH),
    parameter int BEAT_CNT_WIDTH = 32,
    parameter int SPARSITY_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_Start,
    input  logic [BEAT_CNT_WIDTH-1:0] i_RefBeats,
    input  logic [BEAT_CNT_WIDTH-1:0] i_CmpBeats,
    input  logic [SPARSITY_WIDTH-1:0] i_Sparsity,
    input  logic [31:0]               i_Seed,
    input  logic                      i_Ready,
    output logic [BUS_WIDTH-1:0]      o_Vector,
    output logic                      o_Valid,
    output logic                      o_Last,
    output logic [CNT_WIDTH-1:0]      o_BRAM_Addr,
    output logic [CNT_WIDTH:0]        o_BRAM_Din,
    output logic                      o_BRAM_WrEn,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic [BEAT_CNT_WIDTH:0]   o_BeatCnt
);

    localparam int                   TOT_W   = BEAT_CNT_WIDTH + 1;
    localparam logic [TOT_W-1:0]     TOT_ONE = TOT_W'(1);
    localparam logic [TOT_W-1:0]     TOT_TWO = TOT_W'(2);
    localparam logic [SPARSITY_WIDTH-1:0] SP_ONE = SPARSITY_WIDTH'(1);

`ifdef TANIMOTO_STIM_THRESH_LOAD_EN
    localparam state_e               START_TGT = ST_THRESH;
    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(VECTOR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ADDR_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   DIN_ONE   = (CNT_WIDTH + 1)'(1);
`else
    localparam state_e               START_TGT = ST_STREAM;
`endif

    state_e                    state, state_nxt;
    logic [TOT_W-1:0]          total, ld_total;
    logic [SPARSITY_WIDTH-1:0] spar, gap, ld_spar;
    logic [31:0]               lfsr, seed_eff, gen_in, gen_out;
    logic [BUS_WIDTH-1:0]      gen_data;
    logic                      accept, enter_stream;

    assign accept       = o_Valid && i_Ready;
    assign seed_eff     = (i_Seed == '0) ? LFSR_SEED_DEFAULT : i_Seed;
    // Direct IDLE->STREAM entry must see the start-time inputs before they are latched.
    assign ld_total     = (state == ST_IDLE) ? ({1'b0, i_RefBeats} + {1'b0, i_CmpBeats}) : total;
    assign ld_spar      = (state == ST_IDLE) ? i_Sparsity : spar;
    assign gen_in       = (state == ST_IDLE) ? seed_eff : lfsr;
    assign enter_stream = (state != ST_STREAM) && (state_nxt == ST_STREAM);

    lfsr_word_gen #(.NUM_WORDS(BUS_WIDTH / 32)) u_gen (
        .state_in  (gen_in),
        .state_out (gen_out),
        .data      (gen_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (i_Start) state_nxt = START_TGT;
`ifdef TANIMOTO_STIM_THRESH_LOAD_EN
            ST_THRESH: if (o_BRAM_Addr == ADDR_LAST) state_nxt = ST_STREAM;
`endif
            ST_STREAM: if (total == '0 || (accept && o_Last)) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // lfsr always holds the state for the beat after the one in o_Vector.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            total     <= '0;
            spar      <= '0;
            gap       <= '0;
            lfsr      <= LFSR_SEED_DEFAULT;
            o_Vector  <= '0;
            o_Valid   <= 1'b0;
            o_Last    <= 1'b0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_BeatCnt <= '0;
        end else begin
            o_Busy <= (state_nxt == ST_THRESH) || (state_nxt == ST_STREAM);
            o_Done <= (state_nxt == ST_DONE);
            if (state == ST_IDLE && i_Start) begin
                total     <= ld_total;
                spar      <= i_Sparsity;
                lfsr      <= seed_eff;
                o_BeatCnt <= '0;
            end
            if (enter_stream) begin
                o_Vector <= gen_data;
                lfsr     <= gen_out;
                gap      <= ld_spar;
                o_Valid  <= (ld_spar == '0) && (ld_total != '0);
                o_Last   <= (ld_spar == '0) && (ld_total == TOT_ONE);
            end else if (state == ST_STREAM) begin
                if (accept) begin
                    o_BeatCnt <= o_BeatCnt + TOT_ONE;
                    o_Vector  <= gen_data;
                    lfsr      <= gen_out;
                    gap       <= spar;
                    o_Valid   <= (spar == '0) && !o_Last;
                    o_Last    <= (spar == '0) && (o_BeatCnt + TOT_TWO == total);
                end else if (!o_Valid && total != '0) begin
                    if (gap != '0) gap <= gap - SP_ONE;
                    o_Valid <= (gap <= SP_ONE);
                    o_Last  <= (gap <= SP_ONE) && (o_BeatCnt + TOT_ONE == total);
                end
            end else begin
                o_Valid <= 1'b0;
                o_Last  <= 1'b0;
            end
        end
    end

`ifdef TANIMOTO_STIM_THRESH_LOAD_EN
    // Ramp table: address k receives k+1.
    always_ff @(posedge clk) begin
        if (!rstn || state_nxt != ST_THRESH) begin
            o_BRAM_Addr <= '0;
            o_BRAM_Din  <= '0;
            o_BRAM_WrEn <= 1'b0;
        end else begin
            o_BRAM_WrEn <= 1'b1;
            if (state == ST_THRESH) begin
                o_BRAM_Addr <= o_BRAM_Addr + ADDR_ONE;
                o_BRAM_Din  <= o_BRAM_Din + DIN_ONE;
            end else begin
                o_BRAM_Addr <= '0;
                o_BRAM_Din  <= DIN_ONE;
            end
        end
    end
`else
    assign o_BRAM_Addr = '0;
    assign o_BRAM_Din  = '0;
    assign o_BRAM_WrEn = 1'b0;
`endif

endmodule
